// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap-RAM arbiter.
package fir_pkg;

  // Which requester owns the tap BRAM port in a given cycle.
  typedef enum logic [1:0] {SRC_NONE, SRC_PE, SRC_WR, SRC_RD} src_e;

  // Default number of cycles a Lite request may lose to the PE.
  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  // Byte offset of the tap region in the AXI-Lite map; addresses reaching
  // the arbiter already have it removed.
  localparam logic [11:0] TAP_BASE = 12'h080;

  // Round-robin pointer encoding.
  localparam logic RR_WR_FIRST = 1'b0;
  localparam logic RR_RD_FIRST = 1'b1;

endpackage

// File: rtl/fir_lite_rr.sv
// Two-way round-robin between the Lite write and read paths.
module fir_lite_rr
  import fir_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  logic rd_elig,
  input  logic rr_ptr,
  input  logic lite_taken,
  output src_e winner,
  output logic rr_ptr_nxt
);

  logic rd_ok;

  // Pick the Lite winner; the pointer only matters when both contend.
  always_comb begin
    winner = SRC_NONE;
    rd_ok  = rd_req & rd_elig;
    if (wr_req && rd_ok) begin
      winner = (rr_ptr == RR_RD_FIRST) ? SRC_RD : SRC_WR;
    end else if (wr_req) begin
      winner = SRC_WR;
    end else if (rd_ok) begin
      winner = SRC_RD;
    end
  end

  // Pointer flips after every Lite grant, whichever side won.
  always_comb begin
    rr_ptr_nxt = lite_taken ? ~rr_ptr : rr_ptr;
  end

endmodule

// File: rtl/fir_tap_arbiter.sv
// Single-port tap-RAM arbiter: PE has priority, Lite write/read share a
// round-robin slot, and an aging counter forces a Lite grant after
// pMAX_WAIT lost cycles. Optional write lock: define FIR_TAP_WR_LOCK_EN.
module fir_tap_arbiter
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pMAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   busy,
  input  logic                   pe_req,
  input  logic [pADDR_WIDTH-1:0] pe_addr,
  output logic                   pe_gnt,
  output logic                   pe_rvalid,
  output logic [pDATA_WIDTH-1:0] pe_rdata,
  input  logic                   wr_req,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  output logic                   wr_gnt,
  output logic                   wr_err,
  input  logic                   rd_req,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_gnt,
  output logic                   rd_rvalid,
  output logic [pDATA_WIDTH-1:0] rd_rdata,
  input  logic                   rd_rready,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam int unsigned CntW = $clog2(pMAX_WAIT + 1);

  src_e            src_d, src_q, lite_win;
  logic            rr_ptr_q, rr_ptr_nxt;
  logic [CntW-1:0] wait_cnt_d, wait_cnt_q;
  logic            rd_rvalid_q;
  logic [pDATA_WIDTH-1:0] rd_rdata_q;
  logic            rd_elig, lite_pend, lite_force, lite_taken;

  // A new Lite read waits until the previous one has fully returned.
  assign rd_elig    = ~rd_rvalid_q & (src_q != SRC_RD);
  assign lite_pend  = (lite_win != SRC_NONE);
  assign lite_force = (wait_cnt_q == CntW'(pMAX_WAIT));
  assign lite_taken = wr_gnt | rd_gnt;

  fir_lite_rr u_lite_rr (
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .rd_elig    (rd_elig),
    .rr_ptr     (rr_ptr_q),
    .lite_taken (lite_taken),
    .winner     (lite_win),
    .rr_ptr_nxt (rr_ptr_nxt)
  );

  // Priority: PE first unless the aged Lite request must be forced through.
  always_comb begin
    src_d = SRC_NONE;
    if (!axis_rst) begin
      if (pe_req && !(lite_pend && lite_force)) begin
        src_d = SRC_PE;
      end else if (lite_pend) begin
        src_d = lite_win;
      end
    end
    pe_gnt = (src_d == SRC_PE);
    wr_gnt = (src_d == SRC_WR);
    rd_gnt = (src_d == SRC_RD);
  end

  // Aging counter: counts Lite cycles lost to the PE, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (lite_taken || !lite_pend) begin
      wait_cnt_d = '0;
    end else if (pe_gnt && !lite_force) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  // BRAM port drive from the current winner.
  always_comb begin
    tap_EN = pe_gnt | wr_gnt | rd_gnt;
    tap_Di = axis_rst ? '0 : wr_data;
    unique case (src_d)
      SRC_PE:  tap_A = pe_addr;
      SRC_WR:  tap_A = wr_addr;
      SRC_RD:  tap_A = rd_addr;
      default: tap_A = '0;
    endcase
  end

`ifdef FIR_TAP_WR_LOCK_EN
  // Writes during a run still consume their grant but never reach the RAM.
  always_comb begin
    wr_err = wr_gnt & busy;
    tap_WE = {4{wr_gnt & ~busy}};
  end
`else
  logic unused_busy;
  assign unused_busy = busy;

  // Writes go straight through regardless of run state.
  always_comb begin
    wr_err = 1'b0;
    tap_WE = {4{wr_gnt}};
  end
`endif

  // Source pipeline, arbitration state and Lite read-return register.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      src_q       <= SRC_NONE;
      rr_ptr_q    <= RR_WR_FIRST;
      wait_cnt_q  <= '0;
      rd_rvalid_q <= 1'b0;
      rd_rdata_q  <= '0;
    end else begin
      src_q      <= src_d;
      rr_ptr_q   <= rr_ptr_nxt;
      wait_cnt_q <= wait_cnt_d;
      if (rd_gnt) begin
        rd_rvalid_q <= 1'b1;
      end else if (rd_rvalid_q && rd_rready) begin
        rd_rvalid_q <= 1'b0;
      end
      if (src_q == SRC_RD) begin
        rd_rdata_q <= tap_Do;
      end
    end
  end

  // Returned data: PE is a pass-through; Lite data is shown live in the
  // return cycle and held from the register afterwards.
  always_comb begin
    pe_rvalid = (src_q == SRC_PE);
    pe_rdata  = axis_rst ? '0 : tap_Do;
    rd_rvalid = rd_rvalid_q;
    rd_rdata  = (src_q == SRC_RD) ? tap_Do : rd_rdata_q;
  end

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Directed bench for fir_tap_arbiter with a behavioural 1-cycle tap BRAM.
module tb_fir_tap_arbiter;

  logic        axis_clk = 1'b0;
  logic        axis_rst, busy;
  logic        pe_req, pe_gnt, pe_rvalid;
  logic [11:0] pe_addr;
  logic [31:0] pe_rdata;
  logic        wr_req, wr_gnt, wr_err;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_req, rd_gnt, rd_rvalid, rd_rready;
  logic [11:0] rd_addr;
  logic [31:0] rd_rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_A_ext, tap_Do;
  logic [11:0] tap_A;

  logic [31:0] mem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 axis_clk = ~axis_clk;

  fir_tap_arbiter dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .busy      (busy),
    .pe_req    (pe_req),
    .pe_addr   (pe_addr),
    .pe_gnt    (pe_gnt),
    .pe_rvalid (pe_rvalid),
    .pe_rdata  (pe_rdata),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .wr_err    (wr_err),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .rd_rready (rd_rready),
    .tap_WE    (tap_WE),
    .tap_EN    (tap_EN),
    .tap_Di    (tap_Di),
    .tap_A     (tap_A),
    .tap_Do    (tap_Do)
  );

  assign tap_A_ext = {20'h0, tap_A};

  // Tap BRAM: byte-enabled write, registered read (old data on collision).
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (tap_WE[b]) mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      end
      tap_Do <= mem[tap_A[11:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    tap_Do    = '0;
    axis_rst  = 1'b1;
    busy      = 1'b0;
    pe_req    = 1'b1;
    pe_addr   = 12'h0;
    wr_req    = 1'b1;
    wr_addr   = 12'h0;
    wr_data   = 32'h0;
    rd_req    = 1'b0;
    rd_addr   = 12'h0;
    rd_rready = 1'b0;

    // Reset: grants forced low even with requests up.
    step();
    step();
    check_eq("rst_pe_gnt", {31'h0, pe_gnt}, 32'h0);
    check_eq("rst_wr_gnt", {31'h0, wr_gnt}, 32'h0);
    check_eq("rst_tap_en", {31'h0, tap_EN}, 32'h0);
    check_eq("rst_tap_a", tap_A_ext, 32'h0);
    check_eq("rst_pe_rvalid", {31'h0, pe_rvalid}, 32'h0);
    check_eq("rst_rd_rvalid", {31'h0, rd_rvalid}, 32'h0);
    check_eq("rst_rd_rdata", rd_rdata, 32'h0);
    check_eq("rst_wr_err", {31'h0, wr_err}, 32'h0);
    pe_req   = 1'b0;
    wr_req   = 1'b0;
    axis_rst = 1'b0;
    step();

    // PE streaming reads 0x0..0x28.
    for (int i = 0; i <= 10; i++) begin
      pe_req  = 1'b1;
      pe_addr = 12'(i * 4);
      #1;
      check_eq("pe_gnt", {31'h0, pe_gnt}, 32'h1);
      check_eq("pe_tap_a", tap_A_ext, 32'(i * 4));
      check_eq("pe_tap_we", {28'h0, tap_WE}, 32'h0);
      if (i > 0) begin
        check_eq("pe_rvalid", {31'h0, pe_rvalid}, 32'h1);
        check_eq("pe_rdata", pe_rdata, 32'h1000 + 32'(i - 1));
      end
      step();
    end
    pe_req = 1'b0;
    #1;
    check_eq("pe_last_rvalid", {31'h0, pe_rvalid}, 32'h1);
    check_eq("pe_last_rdata", pe_rdata, 32'h0000_100A);
    check_eq("idle_tap_en", {31'h0, tap_EN}, 32'h0);
    step();
    check_eq("pe_rvalid_drop", {31'h0, pe_rvalid}, 32'h0);

    // Lite write 0x08 <= 5, then read it back.
    wr_req  = 1'b1;
    wr_addr = 12'h008;
    wr_data = 32'h5;
    #1;
    check_eq("wr_gnt", {31'h0, wr_gnt}, 32'h1);
    check_eq("wr_tap_we", {28'h0, tap_WE}, 32'hF);
    check_eq("wr_tap_a", tap_A_ext, 32'h8);
    check_eq("wr_tap_di", tap_Di, 32'h5);
    step();
    wr_req    = 1'b0;
    rd_req    = 1'b1;
    rd_addr   = 12'h008;
    rd_rready = 1'b1;
    #1;
    check_eq("rd_gnt", {31'h0, rd_gnt}, 32'h1);
    check_eq("rd_tap_a", tap_A_ext, 32'h8);
    step();
    rd_req = 1'b0;
    #1;
    check_eq("rd_rvalid", {31'h0, rd_rvalid}, 32'h1);
    check_eq("rd_back_08", rd_rdata, 32'h5);
    step();
    check_eq("rd_rvalid_drop", {31'h0, rd_rvalid}, 32'h0);
    check_eq("rd_rdata_hold", rd_rdata, 32'h5);

    // Starvation: write forced through after 4 lost cycles.
    pe_req  = 1'b1;
    pe_addr = 12'h0;
    wr_req  = 1'b1;
    wr_addr = 12'h00C;
    wr_data = 32'h77;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("starve_pe_gnt", {31'h0, pe_gnt}, 32'h1);
      check_eq("starve_wr_wait", {31'h0, wr_gnt}, 32'h0);
      step();
    end
    #1;
    check_eq("starve_wr_gnt", {31'h0, wr_gnt}, 32'h1);
    check_eq("starve_pe_held", {31'h0, pe_gnt}, 32'h0);
    step();
    wr_req = 1'b0;
    #1;
    check_eq("starve_pe_resume", {31'h0, pe_gnt}, 32'h1);
    check_eq("starve_pe_rvalid0", {31'h0, pe_rvalid}, 32'h0);
    step();
    pe_req = 1'b0;

    // Read backpressure on 0x10.
    rd_req    = 1'b1;
    rd_addr   = 12'h010;
    rd_rready = 1'b0;
    #1;
    check_eq("bp_rd_gnt", {31'h0, rd_gnt}, 32'h1);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_rvalid", {31'h0, rd_rvalid}, 32'h1);
      check_eq("bp_rdata", rd_rdata, 32'h0000_1004);
      check_eq("bp_no_regrant", {31'h0, rd_gnt}, 32'h0);
      step();
    end
    rd_req    = 1'b0;
    rd_rready = 1'b1;
    #1;
    check_eq("bp_rvalid_hs", {31'h0, rd_rvalid}, 32'h1);
    step();
    check_eq("bp_rvalid_drop", {31'h0, rd_rvalid}, 32'h0);

    // Round-robin: write and read alternate, read waits for its return.
    wr_req  = 1'b1;
    wr_addr = 12'h020;
    wr_data = 32'hAA;
    rd_req  = 1'b1;
    rd_addr = 12'h024;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("rr_wr_gnt", {31'h0, wr_gnt}, 32'((c % 2) == 0));
      check_eq("rr_rd_gnt", {31'h0, rd_gnt}, 32'((c % 2) == 1));
      if (c == 2) begin
        check_eq("rr_rvalid", {31'h0, rd_rvalid}, 32'h1);
        check_eq("rr_rdata", rd_rdata, 32'h0000_1009);
      end
      step();
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    step();

    // Reset in the cycle after a read grant discards the return.
    rd_req    = 1'b1;
    rd_addr   = 12'h010;
    rd_rready = 1'b0;
    #1;
    check_eq("rst_mid_rd_gnt", {31'h0, rd_gnt}, 32'h1);
    step();
    rd_req   = 1'b0;
    pe_req   = 1'b1;
    axis_rst = 1'b1;
    #1;
    check_eq("rst_mid_pe_gnt", {31'h0, pe_gnt}, 32'h0);
    step();
    check_eq("rst_mid_rvalid", {31'h0, rd_rvalid}, 32'h0);
    axis_rst  = 1'b0;
    pe_req    = 1'b0;
    rd_rready = 1'b1;
    // Pointer must be back at write-first after reset.
    wr_req  = 1'b1;
    wr_addr = 12'h034;
    wr_data = 32'h55;
    rd_req  = 1'b1;
    rd_addr = 12'h010;
    #1;
    check_eq("rst_rr_wr_first", {31'h0, wr_gnt}, 32'h1);
    step();
    rd_req = 1'b0;

    // Write while busy: lock behaviour depends on the build.
    busy    = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 12'h030;
    wr_data = 32'hDEAD;
    #1;
    check_eq("busy_wr_gnt", {31'h0, wr_gnt}, 32'h1);
`ifdef FIR_TAP_WR_LOCK_EN
    check_eq("lock_wr_err", {31'h0, wr_err}, 32'h1);
    check_eq("lock_tap_we", {28'h0, tap_WE}, 32'h0);
`else
    check_eq("nolock_wr_err", {31'h0, wr_err}, 32'h0);
    check_eq("nolock_tap_we", {28'h0, tap_WE}, 32'hF);
`endif
    step();
    wr_req  = 1'b0;
    busy    = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 12'h030;
    #1;
    check_eq("busy_rd_gnt", {31'h0, rd_gnt}, 32'h1);
    check_eq("busy_wr_err_clr", {31'h0, wr_err}, 32'h0);
    step();
    rd_req = 1'b0;
    #1;
`ifdef FIR_TAP_WR_LOCK_EN
    check_eq("lock_mem_kept", rd_rdata, 32'h0000_100C);
`else
    check_eq("nolock_mem_written", rd_rdata, 32'h0000_DEAD);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_arbiter.md
# fir_tap_arbiter

Single-port tap-RAM arbiter for the FIR block. It shares the tap BRAM between three requesters: the FIR compute engine, which reads coefficients every cycle of a convolution, and the AXI-Lite write and read paths, which program and read back coefficients. It sits between the AXI-Lite front end, the PE address generator and the tap_* BRAM port. It provides fixed priority with a starvation guard and registered read-data return.

## Interface
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, data width
- pMAX_WAIT, 4, number of cycles a pending Lite request may lose to the PE before it is forced through
- axis_clk  in  1  single clock
- axis_rst  in  1  reset, synchronous, active-high
- busy  in  1  FIR run in progress (inverse of ap_idle)
- pe_req  in  1  compute engine requests a tap read
- pe_addr  in  pADDR_WIDTH  tap byte address
- pe_gnt  out  1  PE read issued this cycle
- pe_rvalid  out  1  pe_rdata valid, one cycle after pe_gnt
- pe_rdata  out  pDATA_WIDTH  tap data to the PE
- wr_req  in  1  Lite tap-write request
- wr_addr  in  pADDR_WIDTH  byte address, already offset from the tap base
- wr_data  in  pDATA_WIDTH  coefficient to write
- wr_gnt  out  1  write performed this cycle
- wr_err  out  1  one-cycle pulse when a write is suppressed (macro only)
- rd_req  in  1  Lite tap-read request
- rd_addr  in  pADDR_WIDTH  byte address
- rd_gnt  out  1  read issued this cycle
- rd_rvalid  out  1  rd_rdata held valid
- rd_rdata  out  pDATA_WIDTH  registered read data
- rd_rready  in  1  host accepts rd_rdata
- tap_WE  out  4  BRAM byte write enables
- tap_EN  out  1  BRAM enable
- tap_Di  out  pDATA_WIDTH  BRAM write data
- tap_A  out  pADDR_WIDTH  BRAM address
- tap_Do  in  pDATA_WIDTH  BRAM read data, 1-cycle latency

## Operation
- Requests follow a valid/ready style. A requester holds req and its address/data stable until it sees gnt.
- Grants are combinational in the request cycle. At most one grant per cycle.
- tap_EN = OR of all grants. tap_A = address of the winner, 0 when idle. tap_WE = {4{wr_gnt}}. tap_Di = wr_data.
- Read eligibility: rd_req is eligible only when rd_rvalid=0 and no Lite read is in flight.
- Lite winner: wr_req and an eligible rd_req are arbitrated round-robin through rr_ptr.
  - rr_ptr resets to write-first.
  - rr_ptr flips after each Lite grant.
- Priority:
  - PE wins over the Lite winner unless wait_cnt==pMAX_WAIT.
  - In that case the Lite winner is granted and pe_gnt=0. The PE keeps holding its request.
- wait_cnt:
  - Increments each cycle a Lite request is pending and the PE is granted.
  - Clears on any Lite grant, and when no Lite request is pending.
  - Saturates at pMAX_WAIT.
- PE return: pe_rvalid is pe_gnt delayed one cycle. pe_rdata = tap_Do, passed through with no register.
- Lite read return:
  - In the cycle after rd_gnt, tap_Do is captured into rd_rdata and rd_rvalid is set.
  - rd_rvalid clears on the cycle after rd_rvalid & rd_rready.
  - rd_rdata holds its value until the next capture.
- Simultaneous events:
  - wr_req and rd_req to the same address in the same cycle: resolved by rr_ptr only. No forwarding.
  - rd_rready while rd_rvalid=0: ignored.
- Reset mid-operation:
  - All grants are forced 0 while axis_rst=1.
  - An in-flight Lite read is discarded; rd_rvalid=0 after reset.

## Timing
- Reset values: pe_rvalid=0, rd_rvalid=0, rd_rdata=0, wr_err=0, wait_cnt=0, rr_ptr=write. Combinational outputs are 0 during reset.
- PE read latency: 1 cycle, gnt at N → pe_rvalid at N+1.
- Lite read latency: gnt at N → rd_rvalid at N+1. The earliest next rd_gnt is the cycle after the rd_rvalid&rd_rready handshake.
- Write takes effect at the clock edge of cycle N in which wr_gnt=1.
- Worst-case Lite wait under continuous PE requests: pMAX_WAIT cycles.

## Configuration
- FIR_TAP_WR_LOCK_EN
  - Defined: a write while busy=1 is still granted, but tap_WE=0 and wr_err pulses in the same cycle.
  - Undefined: writes ignore busy, wr_err is tied to 0, and tap_WE follows wr_gnt.

## Structure
- Package fir_pkg holds:
  - the grant-source enum {SRC_NONE, SRC_PE, SRC_WR, SRC_RD}
  - the default for pMAX_WAIT
  - the tap base offset constant
- Sub-module fir_lite_rr: a two-way round-robin between wr and rd. Inputs are the requests and eligibility; outputs are the winner and the rr_ptr update.
- Top-level logic: priority/aging, the one-cycle source pipeline register, and the read-return register.

## Test plan
- Reset, then PE-only traffic: pe_req=1 with addresses 0x0,0x4,…,0x28 → pe_gnt every cycle, pe_rvalid one cycle later with the matching tap_Do, tap_WE=0.
- Lite write with PE idle: wr_addr=0x08, wr_data=0x5 → wr_gnt, tap_WE=4'hF, tap_A=0x08 in the same cycle. A later read of 0x08 returns 5.
- Starvation: pe_req held high and wr_req asserted → wr_gnt exactly pMAX_WAIT(4) cycles later, pe_gnt=0 in that cycle, PE resumes the following cycle.
- Read backpressure: rd_req to 0x10 with rd_rready=0 for 5 cycles → rd_rvalid held and rd_rdata stable, no second rd_gnt. rd_rready=1 → rd_rvalid drops the next cycle.
- Round-robin: wr_req and rd_req both asserted continuously with PE idle → grants alternate write, read, with read re-granted only after its return completes.
- Reset mid-read and lock: assert axis_rst in the cycle after rd_gnt → rd_rvalid=0. With FIR_TAP_WR_LOCK_EN and busy=1, a write → wr_err=1, tap_WE=0, memory unchanged.
